// File: rtl/maf_pkg.sv
// Shared widths, encodings and the beat record for the MAF addend-alignment stage.
package maf_pkg;

    localparam int unsigned MAF_MAN_W   = 24;
    localparam int unsigned MAF_EXP_W   = 10;
    localparam int unsigned MAF_BIAS_F  = 127;
    localparam int unsigned MAF_BIAS_H  = 15;
    localparam int unsigned MAF_ALIGN_W = 3 * MAF_MAN_W + 2;
    localparam int unsigned MAF_SH_W    = 8;

    typedef enum logic {
        MODE_FULL = 1'b0,
        MODE_HALF = 1'b1
    } maf_mode_e;

    typedef enum logic [2:0] {
        TRAP_NONE    = 3'd0,
        TRAP_INVALID = 3'd1,
        TRAP_INF     = 3'd2,
        TRAP_NAN     = 3'd3,
        TRAP_ZERO    = 3'd4
    } maf_trap_e;

    // One stage beat; lane fields are packed exactly as on the output ports.
    typedef struct packed {
        logic                      mode;
        logic [MAF_ALIGN_W-1:0]    c_aligned;
        logic [1:0]                sticky;
        logic [2*MAF_SH_W-1:0]     sh_num;
        logic [MAF_EXP_W-1:0]      e_out;
        logic [1:0]                eff_sub;
        logic [1:0]                c_dom;
        logic [5:0]                trap;
    } maf_beat_t;

endpackage

// File: rtl/maf_align_lane.sv
// One alignment lane: product exponent, addend shift distance, shifted addend and sticky.
module maf_align_lane #(
    parameter int unsigned LMAN   = 24,
    parameter int unsigned LEXP   = 10,
    parameter int unsigned LALIGN = 74,
    parameter int unsigned BIAS   = 127,
    parameter int unsigned SH_W   = 8
) (
    input  logic [LEXP-1:0]   ea,
    input  logic [LEXP-1:0]   eb,
    input  logic [LEXP-1:0]   ec,
    input  logic [LMAN-1:0]   mc,
    input  logic              trap,
    output logic [LALIGN-1:0] c_aligned_c,
    output logic              sticky_c,
    output logic [SH_W-1:0]   sh_c,
    output logic [LEXP-1:0]   e_out_c,
    output logic              c_dom_c
);

    // Three guard bits keep ea+eb-bias-ec+offset from overflowing.
    localparam int unsigned DW = LEXP + 3;

    logic signed [DW-1:0]  ep;
    logic signed [DW-1:0]  d;
    logic [SH_W-1:0]       sh_raw;
    logic [2*LALIGN-1:0]   shifted;

    // Exponent arithmetic, clamped shift, and shift of the left-justified addend.
    always_comb begin
        ep      = $signed(DW'(ea)) + $signed(DW'(eb)) - $signed(DW'(BIAS));
        d       = ep - $signed(DW'(ec)) + $signed(DW'(LMAN + 3));
        c_dom_c = (d <= $signed(DW'(0)));
        if (c_dom_c) begin
            sh_raw = '0;
        end else if (d >= $signed(DW'(LALIGN))) begin
            sh_raw = SH_W'(LALIGN);
        end else begin
            sh_raw = SH_W'(d);
        end
        // Lower half collects everything pushed past the lane LSB.
        shifted     = {mc, {(2*LALIGN-LMAN){1'b0}}} >> sh_raw;
        e_out_c     = c_dom_c ? ec : LEXP'(ep + $signed(DW'(3)));
        sh_c        = trap ? '0 : sh_raw;
        c_aligned_c = trap ? '0 : shifted[2*LALIGN-1:LALIGN];
        sticky_c    = trap ? 1'b0 : (|shifted[LALIGN-1:0]);
    end

endmodule

// File: rtl/maf_align_stage.sv
// MAF addend-alignment stage: full or dual-half lanes, 1-cycle latency, output reg + skid reg.
module maf_align_stage
    import maf_pkg::*;
#(
    parameter  int unsigned MAN_W   = MAF_MAN_W,
    parameter  int unsigned EXP_W   = MAF_EXP_W,
    parameter  int unsigned BIAS_F  = MAF_BIAS_F,
    parameter  int unsigned BIAS_H  = MAF_BIAS_H,
    localparam int unsigned ALIGN_W = 3 * MAN_W + 2,
    localparam int unsigned SH_MAX  = ALIGN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [EXP_W-1:0]   e_a,
    input  logic [EXP_W-1:0]   e_b,
    input  logic [EXP_W-1:0]   e_c,
    input  logic [MAN_W-1:0]   m_c,
    input  logic [1:0]         s_a,
    input  logic [1:0]         s_b,
    input  logic [1:0]         s_c,
    input  logic [5:0]         trap_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               mode_o,
    output logic [ALIGN_W-1:0] c_aligned,
    output logic [1:0]         sticky,
    output logic [15:0]        sh_num,
    output logic [EXP_W-1:0]   e_out,
    output logic [1:0]         eff_sub,
    output logic [1:0]         c_dom,
    output logic [5:0]         trap_out
);

    localparam int unsigned HMAN   = MAN_W / 2;
    localparam int unsigned HEXP   = EXP_W / 2;
    localparam int unsigned HALIGN = ALIGN_W / 2;

    logic [ALIGN_W-1:0] f_ca;
    logic [HALIGN-1:0]  h0_ca, h1_ca;
    logic               f_st, h0_st, h1_st;
    logic [7:0]         f_sh, h0_sh, h1_sh;
    logic [EXP_W-1:0]   f_e;
    logic [HEXP-1:0]    h0_e, h1_e;
    logic               f_cd, h0_cd, h1_cd;

    maf_beat_t beat_c;
    maf_beat_t out_q, out_nxt, skid_q, skid_nxt;
    logic      out_valid_nxt, skid_full, skid_full_nxt, in_ready_nxt, accept_c;

    maf_align_lane #(.LMAN(MAN_W), .LEXP(EXP_W), .LALIGN(SH_MAX), .BIAS(BIAS_F), .SH_W(8)) u_full (
        .ea(e_a), .eb(e_b), .ec(e_c), .mc(m_c), .trap(trap_in[2:0] != TRAP_NONE),
        .c_aligned_c(f_ca), .sticky_c(f_st), .sh_c(f_sh), .e_out_c(f_e), .c_dom_c(f_cd)
    );

    maf_align_lane #(.LMAN(HMAN), .LEXP(HEXP), .LALIGN(HALIGN), .BIAS(BIAS_H), .SH_W(8)) u_half0 (
        .ea(e_a[HEXP-1:0]), .eb(e_b[HEXP-1:0]), .ec(e_c[HEXP-1:0]), .mc(m_c[HMAN-1:0]),
        .trap(trap_in[2:0] != TRAP_NONE),
        .c_aligned_c(h0_ca), .sticky_c(h0_st), .sh_c(h0_sh), .e_out_c(h0_e), .c_dom_c(h0_cd)
    );

    maf_align_lane #(.LMAN(HMAN), .LEXP(HEXP), .LALIGN(HALIGN), .BIAS(BIAS_H), .SH_W(8)) u_half1 (
        .ea(e_a[EXP_W-1:HEXP]), .eb(e_b[EXP_W-1:HEXP]), .ec(e_c[EXP_W-1:HEXP]), .mc(m_c[MAN_W-1:HMAN]),
        .trap(trap_in[5:3] != TRAP_NONE),
        .c_aligned_c(h1_ca), .sticky_c(h1_st), .sh_c(h1_sh), .e_out_c(h1_e), .c_dom_c(h1_cd)
    );

    // Select full-lane or dual-half results; lane 1 fields stay zero in full mode.
    always_comb begin
        beat_c      = '0;
        beat_c.mode = mode;
        beat_c.trap = trap_in;
        if (mode == MODE_HALF) begin
            beat_c.c_aligned = {h1_ca, h0_ca};
            beat_c.sticky    = {h1_st, h0_st};
            beat_c.sh_num    = {h1_sh, h0_sh};
            beat_c.e_out     = {h1_e, h0_e};
            beat_c.eff_sub   = s_a ^ s_b ^ s_c;
            beat_c.c_dom     = {h1_cd, h0_cd};
        end else begin
            beat_c.c_aligned = f_ca;
            beat_c.sticky    = {1'b0, f_st};
            beat_c.sh_num    = {8'd0, f_sh};
            beat_c.e_out     = f_e;
            beat_c.eff_sub   = {1'b0, s_a[0] ^ s_b[0] ^ s_c[0]};
            beat_c.c_dom     = {1'b0, f_cd};
        end
    end

    // Output/skid control: skid drains first so beat order is preserved.
    always_comb begin
        out_valid_nxt = out_valid;
        out_nxt       = out_q;
        skid_full_nxt = skid_full;
        skid_nxt      = skid_q;
        accept_c      = in_valid & in_ready & ~flush;
        if (flush) begin
            out_valid_nxt = 1'b0;
            skid_full_nxt = 1'b0;
        end else if (!out_valid || out_ready) begin
            if (skid_full) begin
                out_nxt       = skid_q;
                out_valid_nxt = 1'b1;
                skid_full_nxt = 1'b0;
            end else if (accept_c) begin
                out_nxt       = beat_c;
                out_valid_nxt = 1'b1;
            end else begin
                out_valid_nxt = 1'b0;
            end
        end else if (accept_c) begin
            skid_nxt      = beat_c;
            skid_full_nxt = 1'b1;
        end
        in_ready_nxt = ~skid_full_nxt;
    end

    // State and data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            skid_full <= 1'b0;
            in_ready  <= 1'b0;
            out_q     <= '0;
            skid_q    <= '0;
        end else begin
            out_valid <= out_valid_nxt;
            skid_full <= skid_full_nxt;
            in_ready  <= in_ready_nxt;
            out_q     <= out_nxt;
            skid_q    <= skid_nxt;
        end
    end

    assign mode_o    = out_q.mode;
    assign c_aligned = out_q.c_aligned;
    assign sticky    = out_q.sticky;
    assign sh_num    = out_q.sh_num;
    assign e_out     = out_q.e_out;
    assign eff_sub   = out_q.eff_sub;
    assign c_dom     = out_q.c_dom;
    assign trap_out  = out_q.trap;

endmodule

// File: tb/tb_maf_align_stage.sv
// Directed-vector bench for maf_align_stage: lane arithmetic table plus stall/flush/reset sequences.
module tb_maf_align_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, mode, out_valid, out_ready, mode_o;
    logic [9:0]  e_a, e_b, e_c, e_out;
    logic [23:0] m_c;
    logic [1:0]  s_a, s_b, s_c, sticky, eff_sub, c_dom;
    logic [5:0]  trap_in, trap_out;
    logic [73:0] c_aligned;
    logic [15:0] sh_num;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        mode;
        logic [9:0]  e_a, e_b, e_c;
        logic [23:0] m_c;
        logic [1:0]  s_a, s_b, s_c;
        logic [5:0]  trap;
        logic [73:0] x_ca;
        logic [1:0]  x_st;
        logic [15:0] x_sh;
        logic [9:0]  x_e;
        logic [1:0]  x_es;
        logic [1:0]  x_cd;
    } vec_t;

    vec_t vecs [12];

    maf_align_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .e_a(e_a), .e_b(e_b), .e_c(e_c), .m_c(m_c),
        .s_a(s_a), .s_b(s_b), .s_c(s_c), .trap_in(trap_in),
        .out_valid(out_valid), .out_ready(out_ready), .mode_o(mode_o),
        .c_aligned(c_aligned), .sticky(sticky), .sh_num(sh_num), .e_out(e_out),
        .eff_sub(eff_sub), .c_dom(c_dom), .trap_out(trap_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required normal finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        mode    = v.mode;
        e_a     = v.e_a;
        e_b     = v.e_b;
        e_c     = v.e_c;
        m_c     = v.m_c;
        s_a     = v.s_a;
        s_b     = v.s_b;
        s_c     = v.s_c;
        trap_in = v.trap;
    endtask

    task automatic check_beat(input string tag, input vec_t v);
        check({tag, ".out_valid"}, 128'(out_valid), 128'(1'b1));
        check({tag, ".mode_o"},    128'(mode_o),    128'(v.mode));
        check({tag, ".c_aligned"}, 128'(c_aligned), 128'(v.x_ca));
        check({tag, ".sticky"},    128'(sticky),    128'(v.x_st));
        check({tag, ".sh_num"},    128'(sh_num),    128'(v.x_sh));
        check({tag, ".e_out"},     128'(e_out),     128'(v.x_e));
        check({tag, ".eff_sub"},   128'(eff_sub),   128'(v.x_es));
        check({tag, ".c_dom"},     128'(c_dom),     128'(v.x_cd));
        check({tag, ".trap_out"},  128'(trap_out),  128'(v.trap));
    endtask

    initial begin
        // mode, e_a, e_b, e_c, m_c, s_a, s_b, s_c, trap | c_aligned, sticky, sh_num, e_out, eff_sub, c_dom
        vecs[0]  = '{1'b0, 10'd127, 10'd127, 10'd127, 24'h800000, 2'b00, 2'b00, 2'b00, 6'd0,
                     74'd1 << 46, 2'b00, 16'd27, 10'd130, 2'b00, 2'b00};
        vecs[1]  = '{1'b0, 10'd100, 10'd120, 10'd153, 24'hABCDEF, 2'b11, 2'b00, 2'b00, 6'd0,
                     {24'hABCDEF, 50'd0}, 2'b00, 16'd0, 10'd153, 2'b01, 2'b01};
        vecs[2]  = '{1'b0, 10'd200, 10'd127, 10'd27, 24'hC00001, 2'b00, 2'b01, 2'b01, 6'd0,
                     74'd0, 2'b01, 16'd74, 10'd203, 2'b00, 2'b00};
        vecs[3]  = '{1'b0, 10'd127, 10'd127, 10'd94, 24'hFFFFFF, 2'b01, 2'b00, 2'b00, 6'd0,
                     74'h3FFF, 2'b01, 16'd60, 10'd130, 2'b01, 2'b00};
        vecs[4]  = '{1'b0, 10'd127, 10'd127, 10'd154, 24'h800001, 2'b00, 2'b00, 2'b00, 6'd0,
                     {24'h800001, 50'd0}, 2'b00, 16'd0, 10'd154, 2'b00, 2'b01};
        vecs[5]  = '{1'b0, 10'd127, 10'd127, 10'd153, 24'h800001, 2'b00, 2'b00, 2'b00, 6'd0,
                     {1'b0, 24'h800001, 49'd0}, 2'b00, 16'd1, 10'd130, 2'b00, 2'b00};
        vecs[6]  = '{1'b0, 10'd174, 10'd127, 10'd128, 24'h800000, 2'b00, 2'b00, 2'b00, 6'd0,
                     74'd1, 2'b00, 16'd73, 10'd177, 2'b00, 2'b00};
        vecs[7]  = '{1'b0, 10'd174, 10'd127, 10'd127, 24'h000001, 2'b00, 2'b00, 2'b00, 6'd0,
                     74'd0, 2'b01, 16'd74, 10'd177, 2'b00, 2'b00};
        vecs[8]  = '{1'b0, 10'd127, 10'd127, 10'd127, 24'h800000, 2'b00, 2'b00, 2'b00, 6'b000010,
                     74'd0, 2'b00, 16'd0, 10'd130, 2'b00, 2'b00};
        vecs[9]  = '{1'b1, {5'd15, 5'd16}, {5'd15, 5'd14}, {5'd15, 5'd10}, {12'h800, 12'hFFF},
                     2'b10, 2'b00, 2'b01, {3'b000, 3'b001},
                     {37'd1 << 21, 37'd0}, 2'b00, {8'd15, 8'd0}, {5'd18, 5'd18}, 2'b11, 2'b00};
        vecs[10] = '{1'b1, {5'd30, 5'd10}, {5'd30, 5'd10}, {5'd0, 5'd31}, {12'h001, 12'hABC},
                     2'b11, 2'b11, 2'b11, 6'd0,
                     {37'd0, 12'hABC, 25'd0}, 2'b10, {8'd37, 8'd0}, {5'd16, 5'd31}, 2'b11, 2'b01};
        vecs[11] = '{1'b1, {5'd20, 5'd15}, {5'd20, 5'd15}, {5'd20, 5'd0}, {12'hFFF, 12'hFFF},
                     2'b00, 2'b00, 2'b00, {3'b100, 3'b000},
                     {37'd0, 37'h7F}, 2'b01, {8'd0, 8'd30}, {5'd28, 5'd18}, 2'b00, 2'b00};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        mode = 1'b0; e_a = '0; e_b = '0; e_c = '0; m_c = '0;
        s_a = '0; s_b = '0; s_c = '0; trap_in = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.out_valid", 128'(out_valid), 128'(0));
        check("rst.c_aligned", 128'(c_aligned), 128'(0));
        check("rst.sh_num",    128'(sh_num),    128'(0));
        check("rst.e_out",     128'(e_out),     128'(0));
        check("rst.trap_out",  128'(trap_out),  128'(0));
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("rst.in_ready_after", 128'(in_ready), 128'(1));

        // Back-to-back table, one beat per cycle
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            apply(vecs[i]);
            @(posedge clk); #1;
            check_beat($sformatf("v%0d", i), vecs[i]);
            check($sformatf("v%0d.in_ready", i), 128'(in_ready), 128'(1));
        end
        @(negedge clk) in_valid = 1'b0;
        @(posedge clk); #1;
        check("idle.out_valid", 128'(out_valid), 128'(0));

        // Stall: three beats offered, two held, order kept on release
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; apply(vecs[0]);
        @(posedge clk); #1;
        check_beat("stall0", vecs[0]);
        @(negedge clk) apply(vecs[1]);
        @(posedge clk); #1;
        check("stall1.in_ready", 128'(in_ready), 128'(0));
        check_beat("stall1.hold", vecs[0]);
        @(negedge clk) apply(vecs[2]);
        @(posedge clk); #1;
        check("stall2.in_ready", 128'(in_ready), 128'(0));
        check_beat("stall2.hold", vecs[0]);
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk); #1;
        check_beat("release.b1", vecs[1]);
        check("release.in_ready", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        check_beat("release.b2", vecs[2]);
        @(negedge clk) in_valid = 1'b0;
        @(posedge clk); #1;
        check("release.drained", 128'(out_valid), 128'(0));

        // Flush with output and skid both full
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; apply(vecs[3]);
        @(negedge clk) apply(vecs[4]);
        @(posedge clk); #1;
        check("full.in_ready",  128'(in_ready),  128'(0));
        check("full.out_valid", 128'(out_valid), 128'(1));
        @(negedge clk);
        flush = 1'b1; apply(vecs[5]);
        @(posedge clk); #1;
        check("flush.out_valid", 128'(out_valid), 128'(0));
        check("flush.in_ready",  128'(in_ready),  128'(1));
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("flush.no_replay", 128'(out_valid), 128'(0));

        // Beat presented during flush while ready is dropped
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; apply(vecs[6]);
        @(posedge clk); #1;
        check("flush2.dropped", 128'(out_valid), 128'(0));
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        check("flush2.after", 128'(out_valid), 128'(0));

        // Asynchronous reset mid-stream
        @(negedge clk);
        in_valid = 1'b1; apply(vecs[7]);
        @(posedge clk); #1;
        check_beat("prerst", vecs[7]);
        #1 rst = 1'b1;
        #1;
        check("arst.out_valid", 128'(out_valid), 128'(0));
        check("arst.c_aligned", 128'(c_aligned), 128'(0));
        check("arst.sticky",    128'(sticky),    128'(0));
        check("arst.e_out",     128'(e_out),     128'(0));
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        check("arst.in_ready",  128'(in_ready),  128'(1));
        check("arst.no_output", 128'(out_valid), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/maf_align_stage.md
MAF_ALIGN_STAGE -- requirements
Module: maf_align_stage

Interface
REQ-001 SHALL have parameter MAN_W, default 24, full-lane mantissa width (hidden bit included); must be even.
REQ-002 SHALL have parameter EXP_W, default 10, full-lane exponent width; the half lane uses EXP_W/2.
REQ-003 SHALL have parameter BIAS_F, default 127, full-lane bias; BIAS_H, default 15, half-lane bias.
REQ-004 SHALL derive ALIGN_W = 3*MAN_W+2 and SH_MAX = ALIGN_W.
REQ-005 SHALL have ports (one per line):
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous discard of all held entries
in_valid  in  1  input beat valid
in_ready  out  1  stage can accept
mode  in  1  0 = one full lane, 1 = two half lanes
e_a, e_b, e_c  in  EXP_W  exponents; mode 1: lane1 [EXP_W-1:EXP_W/2], lane0 [EXP_W/2-1:0]
m_c  in  MAN_W  addend mantissa; mode 1 split in halves
s_a, s_b, s_c  in  2  signs, bit i = lane i (full lane uses bit 0)
trap_in  in  6  3-bit exception code per lane
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
mode_o  out  1  registered mode
c_aligned  out  ALIGN_W  shifted addend; mode 1 halves per lane
sticky  out  2  OR of addend bits shifted past LSB, per lane
sh_num  out  2*8  clamped shift amount per lane
e_out  out  EXP_W  result exponent, packed as inputs
eff_sub  out  2  s_a^s_b^s_c per lane
c_dom  out  2  addend dominates (raw shift <= 0)
trap_out  out  6  registered trap_in

Function
REQ-006 Per lane, the stage SHALL compute ep = ea+eb-BIAS and d = ep-ec+(LMAN+3) in signed arithmetic wide enough for no overflow (EXP_W+3 bits), where LMAN = MAN_W (full) or MAN_W/2 (half).
REQ-007 sh_num SHALL equal clamp(d, 0, LALIGN), where LALIGN = ALIGN_W (full) or ALIGN_W/2 (half).
REQ-008 c_aligned SHALL be {m_c, zeros} placed left-justified in the lane field and then right-shifted by sh_num; sticky SHALL be the OR of the bits shifted out.
REQ-009 d >= LALIGN SHALL yield an all-zero c_aligned lane and sticky = |m_c lane.
REQ-010 c_dom SHALL equal 1 when d <= 0; e_out SHALL equal ec when c_dom, else ep+3, truncated to the lane width.
REQ-011 Any nonzero trap_in lane SHALL force that lane's sh_num, c_aligned and sticky to 0; its other fields follow REQ-006..010.
REQ-012 In mode 0, lane-1 output bits (sticky[1], eff_sub[1], c_dom[1], sh_num[15:8]) SHALL be 0.
REQ-013 Latency SHALL be 1 cycle, from input acceptance (in_valid & in_ready) to out_valid, with no stall.
REQ-014 Storage SHALL be an output register plus one skid register; in_ready = !skid_full, registered, with no combinational path from out_ready.
REQ-015 Output data SHALL stay stable while out_valid & !out_ready.
REQ-016 If the output is stalled, an accepted beat SHALL go to the skid register; on the next out_ready the skid beat moves to the output register in order.
REQ-017 Simultaneous accept and drain SHALL keep throughput at 1 beat/cycle with no bubble.
REQ-018 flush SHALL clear out_valid and skid_full on the next edge, and any beat presented in the same cycle SHALL be dropped.

Reset
REQ-019 rst high SHALL asynchronously clear out_valid, skid_full and every output data register to 0.
REQ-020 in_ready SHALL be 1 from the first edge after rst deasserts.
REQ-021 A beat in flight at reset SHALL be lost without a partial output.

Structure
REQ-022 A shared package maf_pkg SHALL hold MAN_W/EXP_W/BIAS defaults, the mode encoding, the trap code values and a beat-record typedef.
REQ-023 Per-lane arithmetic SHALL be one sub-module, maf_align_lane, instanced for the full lane and for the two half lanes and muxed by mode.

Verification
REQ-024 Mode 0: e_a=e_b=127, e_c=127, m_c=0x800000 -> d=27, sh_num=27, c_dom=0, e_out=130, sticky=0.
REQ-025 Mode 0: e_c=e_a+e_b-127+60 -> c_dom=1, sh_num=0, e_out=e_c, c_aligned top bits equal m_c.
REQ-026 Mode 0: d=200 -> sh_num=74, c_aligned=0, sticky=1.
REQ-027 Mode 1 with lane0 trap=3'b001 and lane1 normal -> lane0 sh/sticky 0; lane1 matches a scalar half-precision model.
REQ-028 Hold out_ready=0 for 3 cycles while sending 3 beats -> 2 beats held, in_ready drops, order is kept after release, and data is unchanged.
REQ-029 Assert flush with both registers full, and assert rst mid-stream -> out_valid=0 next cycle / immediately, and in_ready=1 afterwards.
